// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Shared definitions for the SDRAM controller slice: command encodings on
//   the {cs_n, ras_n, cas_n, we_n} pins and the arbiter state encoding.
//   No ports; imported by sdram_arbiter.
package sdram_pkg;

  // SDRAM commands as driven on {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;

  // Arbiter state encoding
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  typedef enum logic [2:0] {
    S_INIT  = ST_INIT,
    S_IDLE  = ST_IDLE,
    S_AREF  = ST_AREF,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ
  } arbState_e;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the SDRAM command/address/data pins between the init, auto-refresh,
//   write and read engines. Nothing is granted until init_end; refresh always
//   wins in IDLE, and write/read alternate when both are pending. Every grant
//   returns through IDLE, giving at least one NOP cycle between bursts.
//
// Ports
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   init_*                    init engine command/bank/address, init_end level
//   aref_req/end/cmd/addr     refresh engine handshake and command
//   wr_req/end/cmd/ba/addr    write engine handshake and command
//   wr_dq_oe, wr_data         write data and its output enable
//   rd_req/end/cmd/ba/addr    read engine handshake and command
//   aref_en, wr_en, rd_en     registered grants (decode of the state)
//   aref_pending              refresh waiting while a burst is in progress
//   rd_data                   dq bus as seen from the pins
//   sdram_*                   SDRAM pins; sdram_dq is bidirectional
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_dq_oe,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              aref_pending,
  output logic [DQ_W-1:0]   rd_data,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_dqm,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  arbState_e         state_q, state_d;
  logic              lastWr_q, lastWr_d;
  logic              arefEn_q, wrEn_q, rdEn_q;
  logic [3:0]        pinCmd;
  logic [BA_W-1:0]   pinBa;
  logic [ADDR_W-1:0] pinAddr;
  logic              dqOe;

  // Next-state logic. Requests are only looked at in IDLE; end pulses are
  // only honoured from the engine that currently holds the grant, so a stray
  // pulse from anyone else is harmless. lastWr remembers which side finished
  // last so a continuous write+read load alternates fairly.
  always_comb begin
    state_d  = state_q;
    lastWr_d = lastWr_q;
    case (state_q)
      S_INIT: begin
        if (init_end) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (aref_req)              state_d = S_AREF;
        else if (wr_req && rd_req) state_d = lastWr_q ? S_READ : S_WRITE;
        else if (wr_req)           state_d = S_WRITE;
        else if (rd_req)           state_d = S_READ;
      end
      S_AREF: begin
        if (aref_end) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (wr_end) begin
          state_d  = S_IDLE;
          lastWr_d = 1'b1;
        end
      end
      S_READ: begin
        if (rd_end) begin
          state_d  = S_IDLE;
          lastWr_d = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State register. Grants are decoded from the next state so they switch
  // on the same edge as the state itself, and the async reset drops them
  // immediately along with the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_INIT;
      lastWr_q <= 1'b0;
      arefEn_q <= 1'b0;
      wrEn_q   <= 1'b0;
      rdEn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lastWr_q <= lastWr_d;
      arefEn_q <= (state_d == S_AREF);
      wrEn_q   <= (state_d == S_WRITE);
      rdEn_q   <= (state_d == S_READ);
    end
  end

  // Pin mux straight from the state register, so an engine's command reaches
  // the pins in the same cycle it is presented.
  always_comb begin
    pinCmd  = CMD_NOP;
    pinBa   = '0;
    pinAddr = '0;
    case (state_q)
      S_INIT: begin
        pinCmd  = init_cmd;
        pinBa   = init_ba;
        pinAddr = init_addr;
      end
      S_AREF: begin
        pinCmd  = aref_cmd;
        pinAddr = aref_addr;
      end
      S_WRITE: begin
        pinCmd  = wr_cmd;
        pinBa   = wr_ba;
        pinAddr = wr_addr;
      end
      S_READ: begin
        pinCmd  = rd_cmd;
        pinBa   = rd_ba;
        pinAddr = rd_addr;
      end
      default: begin
        pinCmd  = CMD_NOP;
        pinBa   = '0;
        pinAddr = '0;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pinCmd;
  assign sdram_bank = pinBa;
  assign sdram_addr = pinAddr;
  assign sdram_cke  = 1'b1;
  assign sdram_dqm  = 2'b00;

  // The bus is only ever driven by the write engine while it holds the grant.
  assign dqOe     = (state_q == S_WRITE) && wr_dq_oe;
  assign sdram_dq = dqOe ? wr_data : {DQ_W{1'bz}};
  assign rd_data  = sdram_dq;

  // Lets the burst engines cut their burst short when refresh is waiting.
  assign aref_pending = aref_req && ((state_q == S_WRITE) || (state_q == S_READ));

  assign aref_en = arefEn_q;
  assign wr_en   = wrEn_q;
  assign rd_en   = rdEn_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Self-checking bench for sdram_arbiter. Expected grants are queued as the
//   requests are raised and popped when a grant appears; a small model of
//   last-write tracks write/read alternation.
module tb_sdram_arbiter;

  localparam int ADDR_W = 12;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [2:0] G_NONE  = 3'b000;
  localparam logic [2:0] G_AREF  = 3'b100;
  localparam logic [2:0] G_WRITE = 3'b010;
  localparam logic [2:0] G_READ  = 3'b001;

  logic              sys_clk, sys_rst_n;
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req, aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req, wr_end;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_dq_oe;
  logic [DQ_W-1:0]   wr_data;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;
  logic              aref_en, wr_en, rd_en, aref_pending;
  logic [DQ_W-1:0]   rd_data;
  logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BA_W-1:0]   sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [1:0]        sdram_dqm;
  wire  [DQ_W-1:0]   dqBus;

  // SDRAM-side model driver on the data bus
  logic              modelDrive;
  logic [DQ_W-1:0]   modelData;
  assign dqBus = modelDrive ? modelData : {DQ_W{1'bz}};

  int compared;
  int mismatched;
  logic lastWr;
  logic [2:0] expQ[$];

  sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_dq_oe(wr_dq_oe), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .aref_pending(aref_pending),
    .rd_data(rd_data), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm),
    .sdram_dq(dqBus)
  );

  // Free-running clock, 10 time units per cycle
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hard stop in case something stalls far beyond any test's budget
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // One cycle forward; inputs are driven and outputs sampled 1 unit after the edge
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Waits for any grant to rise, bounded by budget cycles
  task automatic waitGrant(input int budget, output logic [2:0] code, output int cycles);
    code   = G_NONE;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      cycles++;
      if ({aref_en, wr_en, rd_en} != G_NONE) begin
        code = {aref_en, wr_en, rd_en};
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    compared++;
    if ({aref_en, wr_en, rd_en} !== G_NONE) begin
      mismatched++;
      $display("[TB] FAIL reset_grants: got %b expected %b", {aref_en, wr_en, rd_en}, G_NONE);
    end
    compared++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr} !== {init_cmd, init_ba, init_addr}) begin
      mismatched++;
      $display("[TB] FAIL reset_pins: got %h expected %h",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr},
               {init_cmd, init_ba, init_addr});
    end
    compared++;
    if ({sdram_cke, sdram_dqm} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL reset_cke_dqm: got %b expected %b", {sdram_cke, sdram_dqm}, 3'b100);
    end
    sys_rst_n = 1'b1;
    // Requests while init is still running must be ignored
    wr_req = 1'b1; rd_req = 1'b1; aref_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if ({aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== {G_NONE, init_cmd}) begin
        mismatched++;
        $display("[TB] FAIL init_hold: got %b expected %b",
                 {aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {G_NONE, init_cmd});
      end
    end
    wr_req = 1'b0; rd_req = 1'b0; aref_req = 1'b0;
    init_end = 1'b1;
    step();
    compared++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr} !== {NOP, 2'b00, 12'h000}) begin
      mismatched++;
      $display("[TB] FAIL init_to_idle: got %h expected %h",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr}, {NOP, 2'b00, 12'h000});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] code, expG;
    int cycles;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      expQ.push_back(lastWr ? G_READ : G_WRITE);
      waitGrant(5, code, cycles);
      expG = (expQ.size() == 0) ? G_NONE : expQ.pop_front();
      compared++;
      if (code !== expG) begin
        mismatched++;
        $display("[TB] FAIL b2b_grant%0d: got %b expected %b", n, code, expG);
      end
      compared++;
      if (cycles !== 1) begin
        mismatched++;
        $display("[TB] FAIL b2b_latency%0d: got %0d expected %0d", n, cycles, 1);
      end
      step(); step();
      if (expG == G_WRITE) begin
        wr_end = 1'b1; step(); wr_end = 1'b0; lastWr = 1'b1;
      end else begin
        rd_end = 1'b1; step(); rd_end = 1'b0; lastWr = 1'b0;
      end
      compared++;
      if ({aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== {G_NONE, NOP}) begin
        mismatched++;
        $display("[TB] FAIL b2b_idle_gap%0d: got %b expected %b", n,
                 {aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {G_NONE, NOP});
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_dq();
    logic [2:0] code, expG;
    int cycles;
    wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 12'h155;
    wr_req = 1'b1;
    expQ.push_back(G_WRITE);
    waitGrant(5, code, cycles);
    expG = (expQ.size() == 0) ? G_NONE : expQ.pop_front();
    compared++;
    if (code !== expG) begin
      mismatched++;
      $display("[TB] FAIL dq_wr_grant: got %b expected %b", code, expG);
    end
    compared++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr} !== {4'b0100, 2'b10, 12'h155}) begin
      mismatched++;
      $display("[TB] FAIL wr_pins: got %h expected %h",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr}, {4'b0100, 2'b10, 12'h155});
    end
    wr_dq_oe = 1'b1; wr_data = 16'hA5A5;
    #1;
    compared++;
    if (dqBus !== 16'hA5A5) begin
      mismatched++;
      $display("[TB] FAIL wr_dq_drive: got %h expected %h", dqBus, 16'hA5A5);
    end
    // A read end pulse while write holds the bus is ignored
    rd_end = 1'b1; step(); rd_end = 1'b0;
    compared++;
    if ({aref_en, wr_en, rd_en} !== G_WRITE) begin
      mismatched++;
      $display("[TB] FAIL stray_rd_end: got %b expected %b", {aref_en, wr_en, rd_en}, G_WRITE);
    end
    wr_dq_oe = 1'b0;
    modelData = 16'h5A5A; modelDrive = 1'b1;
    #1;
    compared++;
    if ({dqBus, rd_data} !== {16'h5A5A, 16'h5A5A}) begin
      mismatched++;
      $display("[TB] FAIL wr_dq_release: got %h expected %h", {dqBus, rd_data}, {16'h5A5A, 16'h5A5A});
    end
    modelDrive = 1'b0;
    wr_req = 1'b0;
    wr_end = 1'b1; step(); wr_end = 1'b0; lastWr = 1'b1;
    rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 12'h0F0;
    rd_req = 1'b1;
    expQ.push_back(G_READ);
    waitGrant(5, code, cycles);
    expG = (expQ.size() == 0) ? G_NONE : expQ.pop_front();
    compared++;
    if (code !== expG) begin
      mismatched++;
      $display("[TB] FAIL dq_rd_grant: got %b expected %b", code, expG);
    end
    compared++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr} !== {4'b0101, 2'b01, 12'h0F0}) begin
      mismatched++;
      $display("[TB] FAIL rd_pins: got %h expected %h",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr}, {4'b0101, 2'b01, 12'h0F0});
    end
    modelData = 16'h1234; modelDrive = 1'b1;
    #1;
    compared++;
    if (rd_data !== 16'h1234) begin
      mismatched++;
      $display("[TB] FAIL rd_data: got %h expected %h", rd_data, 16'h1234);
    end
  endtask

  task automatic test_aref_pending();
    logic [2:0] code, expG;
    int cycles;
    aref_cmd = 4'b0001; aref_addr = 12'h0AB;
    compared++;
    if (aref_pending !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL pending_idle_low: got %b expected %b", aref_pending, 1'b0);
    end
    aref_req = 1'b1;
    #1;
    compared++;
    if (aref_pending !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pending_rise: got %b expected %b", aref_pending, 1'b1);
    end
    step(); step();
    compared++;
    if ({aref_en, wr_en, rd_en} !== G_READ) begin
      mismatched++;
      $display("[TB] FAIL no_preempt: got %b expected %b", {aref_en, wr_en, rd_en}, G_READ);
    end
    expQ.push_back(G_AREF);
    rd_req = 1'b0;
    rd_end = 1'b1; step(); rd_end = 1'b0; lastWr = 1'b0;
    modelDrive = 1'b0;
    compared++;
    if ({aref_en, wr_en, rd_en, aref_pending} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL pending_idle_gap: got %b expected %b", {aref_en, wr_en, rd_en, aref_pending}, 4'b0000);
    end
    waitGrant(5, code, cycles);
    expG = (expQ.size() == 0) ? G_NONE : expQ.pop_front();
    compared++;
    if ({code, cycles[3:0]} !== {expG, 4'd1}) begin
      mismatched++;
      $display("[TB] FAIL pending_aref_grant: got %b/%0d expected %b/1", code, cycles, expG);
    end
    compared++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr} !== {4'b0001, 2'b00, 12'h0AB}) begin
      mismatched++;
      $display("[TB] FAIL aref_pins: got %h expected %h",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr}, {4'b0001, 2'b00, 12'h0AB});
    end
    aref_req = 1'b0;
    step();
    aref_end = 1'b1; step(); aref_end = 1'b0;
  endtask

  task automatic test_aref_priority();
    logic [2:0] code, expG;
    int cycles;
    aref_req = 1'b1; wr_req = 1'b1;
    expQ.push_back(G_AREF);
    expQ.push_back(G_WRITE);
    waitGrant(5, code, cycles);
    expG = (expQ.size() == 0) ? G_NONE : expQ.pop_front();
    compared++;
    if (code !== expG) begin
      mismatched++;
      $display("[TB] FAIL prio_first: got %b expected %b", code, expG);
    end
    aref_req = 1'b0;
    step();
    aref_end = 1'b1; step(); aref_end = 1'b0;
    compared++;
    if ({aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== {G_NONE, NOP}) begin
      mismatched++;
      $display("[TB] FAIL prio_nop_gap: got %b expected %b",
               {aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {G_NONE, NOP});
    end
    waitGrant(5, code, cycles);
    expG = (expQ.size() == 0) ? G_NONE : expQ.pop_front();
    compared++;
    if ({code, cycles[3:0]} !== {expG, 4'd1}) begin
      mismatched++;
      $display("[TB] FAIL prio_second: got %b/%0d expected %b/1", code, cycles, expG);
    end
  endtask

  task automatic test_async_reset();
    wr_dq_oe = 1'b1; wr_data = 16'hA5A5;
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    compared++;
    if ({aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== {G_NONE, init_cmd}) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %b expected %b",
               {aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {G_NONE, init_cmd});
    end
    modelData = 16'h5A5A; modelDrive = 1'b1;
    #1;
    compared++;
    if (dqBus !== 16'h5A5A) begin
      mismatched++;
      $display("[TB] FAIL async_reset_dq: got %h expected %h", dqBus, 16'h5A5A);
    end
    modelDrive = 1'b0;
    wr_req = 1'b0; wr_dq_oe = 1'b0; lastWr = 1'b0;
    sys_rst_n = 1'b1;
    step();
    wr_end = 1'b1; step(); wr_end = 1'b0;
    compared++;
    if ({aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== {G_NONE, NOP}) begin
      mismatched++;
      $display("[TB] FAIL stray_wr_end_idle: got %b expected %b",
               {aref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {G_NONE, NOP});
    end
  endtask

  // Drive every input to a known value, then run the scenarios in order
  initial begin
    compared = 0; mismatched = 0; lastWr = 1'b0;
    sys_rst_n = 1'b0; init_end = 1'b0;
    init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 12'h400;
    aref_req = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001; aref_addr = 12'h000;
    wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b00; wr_addr = 12'h000;
    wr_dq_oe = 1'b0; wr_data = 16'h0000;
    rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b00; rd_addr = 12'h000;
    modelDrive = 1'b0; modelData = 16'h0000;
    test_reset();
    test_back_to_back();
    test_dq();
    test_aref_pending();
    test_aref_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
